// File: rtl/c_mem_pkg.sv
// Shared types and constants for the M-stage data-memory access controller.
package c_mem_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // Plain constants so the state register stays a plain vector
  localparam logic [1:0] S_IDLE = MEM_IDLE;
  localparam logic [1:0] S_BUSY = MEM_BUSY;
  localparam logic [1:0] S_DONE = MEM_DONE;

  function automatic logic is_mem_access(input logic mem_write, input logic [1:0] result_src);
    return mem_write | (result_src == RESULT_SRC_MEM);
  endfunction

endpackage

// File: rtl/c_mem_access_ctrl_if.sv
// Data-memory request bus: controller is master, memory is slave.
interface c_mem_access_ctrl_if
  import c_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/c_mem_timer.sv
// BUSY-phase wait counter; flags the cycle on which the wait limit is hit.
module c_mem_timer #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire_c
);

  localparam int unsigned CLOG_W = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned CNT_W  = (CLOG_W > 8) ? CLOG_W : 8;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // The count reaches TIMEOUT_CYC at the end of this un-ready cycle
  assign o_expire_c = i_count && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/c_mem_access_ctrl.sv
// M-stage data-memory sequencer: stalls the pipe while a load/store is outstanding.
// Optional macro MEM_TIMEOUT_EN aborts an access after TIMEOUT_CYC un-ready BUSY cycles.
module c_mem_access_ctrl
  import c_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 MemWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [ADDR_W-1:0]    ALUResultM,
  input  logic [DATA_W-1:0]    WriteDataM,
  c_mem_access_ctrl_if.master  mem,
  output logic [DATA_W-1:0]    ReadDataM,
  output logic                 StallMem,
  output logic                 FlushW,
  output logic                 MemErr
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_access;
  logic              w_stall;
  logic              w_timeout;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;

  // Next-state and stall decode
  always_comb begin
    w_state_nxt = r_state;
    w_access    = is_mem_access(MemWriteM, ResultSrcM);
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall = w_access;
        if (w_access) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (mem.mem_ready || w_timeout) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request registers; address/data/we are frozen for the whole BUSY phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_mem_req <= (w_state_nxt == S_BUSY);
      if ((r_state == S_IDLE) && w_access) begin
        r_mem_addr  <= ALUResultM;
        r_mem_wdata <= WriteDataM;
        r_mem_we    <= MemWriteM;
      end
      if ((r_state == S_BUSY) && !r_mem_we) begin
        if (mem.mem_ready) begin
          r_rdata <= mem.mem_rdata;
        end else if (w_timeout) begin
          r_rdata <= '0;
        end
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic r_mem_err;

  c_mem_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clear    ((r_state == S_IDLE) && w_access),
    .i_count    ((r_state == S_BUSY) && !mem.mem_ready),
    .o_expire_c (w_timeout)
  );

  // Error pulse lines up with the DONE cycle of an aborted access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_timeout;
    end
  end

  assign MemErr = r_mem_err;
`else
  logic [31:0] w_unused_timeout;

  assign w_unused_timeout = 32'(TIMEOUT_CYC);
  assign w_timeout        = 1'b0;
  assign MemErr           = 1'b0;
`endif

  // Stall is combinational from M-stage decode but forced low during reset
  assign StallMem = reset & w_stall;
  assign FlushW   = StallMem;

  assign mem.mem_req   = r_mem_req;
  assign mem.mem_we    = r_mem_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign ReadDataM     = r_rdata;

endmodule

// File: tb/tb_c_mem_access_ctrl.sv
// Directed bench for c_mem_access_ctrl: vector table plus reset and timeout sequences.
// Define MEM_TIMEOUT_EN to exercise the timeout build (TIMEOUT_CYC = 4).
module tb_c_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TB_TO = 4;
`else
  localparam int unsigned TB_TO = 255;
`endif

  localparam logic [1:0] LD = 2'b01;
  localparam logic [1:0] NO = 2'b00;

  typedef struct packed {
    logic        we;
    logic [1:0]  rs;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] rd;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMem;
  logic        FlushW;
  logic        MemErr;

  int n_vec;
  int n_err;
  int n_hs;

  c_mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  c_mem_access_ctrl #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .TIMEOUT_CYC (TB_TO)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .mem        (bus),
    .ReadDataM  (ReadDataM),
    .StallMem   (StallMem),
    .FlushW     (FlushW),
    .MemErr     (MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic we, input logic [1:0] rs, input logic [31:0] addr,
                              input logic [31:0] wd, input logic rdy, input logic [31:0] rd,
                              input logic e_req, input logic e_we, input logic [31:0] e_addr,
                              input logic [31:0] e_wd, input logic [31:0] e_rd,
                              input logic e_stall, input logic e_err);
    vec_t v;
    v.we = we; v.rs = rs; v.addr = addr; v.wd = wd; v.rdy = rdy; v.rd = rd;
    v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_rd = e_rd; v.e_stall = e_stall; v.e_err = e_err;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    MemWriteM     = v.we;
    ResultSrcM    = v.rs;
    ALUResultM    = v.addr;
    WriteDataM    = v.wd;
    bus.mem_ready = v.rdy;
    bus.mem_rdata = v.rd;
  endtask

  task automatic expect_out(input string nm, input vec_t v);
    logic [100:0] act;
    logic [100:0] exp;
    act = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, ReadDataM, StallMem, FlushW, MemErr};
    exp = {v.e_req, v.e_we, v.e_addr, v.e_wd, v.e_rd, v.e_stall, v.e_stall, v.e_err};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got req=%b we=%b addr=%h wd=%h rd=%h stall=%b flush=%b err=%b, want req=%b we=%b addr=%h wd=%h rd=%h stall=%b flush=%b err=%b",
               nm, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, ReadDataM, StallMem, FlushW, MemErr,
               v.e_req, v.e_we, v.e_addr, v.e_wd, v.e_rd, v.e_stall, v.e_stall, v.e_err);
    end
  endtask

  // One pipeline cycle: drive at edge+1, check at edge+3, advance to next edge+1
  task automatic apply_vec(input string nm, input vec_t v);
    drive(v);
    #2;
    expect_out(nm, v);
    if (bus.mem_req && bus.mem_ready) n_hs++;
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [24];
  vec_t v;

  initial begin
    n_vec = 0;
    n_err = 0;
    n_hs  = 0;

    tbl[0]  = mk(0, LD, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0, 0, 32'h000, 32'h0, 32'h0, 1, 0);
    tbl[1]  = mk(0, LD, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1, 0, 32'h100, 32'h0, 32'h0, 1, 0);
    tbl[2]  = mk(0, LD, 32'h100, 32'h0, 1, 32'hDEADBEEF, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    tbl[3]  = mk(1, NO, 32'h200, 32'h12345678, 0, 32'h0, 0, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 0);
    tbl[4]  = mk(1, NO, 32'h200, 32'h12345678, 0, 32'h0, 1, 1, 32'h200, 32'h12345678, 32'hDEADBEEF, 1, 0);
    tbl[5]  = tbl[4];
    tbl[6]  = tbl[4];
    tbl[7]  = mk(1, NO, 32'h200, 32'h12345678, 1, 32'h0, 1, 1, 32'h200, 32'h12345678, 32'hDEADBEEF, 1, 0);
    tbl[8]  = mk(1, NO, 32'h200, 32'h12345678, 1, 32'h0, 0, 1, 32'h200, 32'h12345678, 32'hDEADBEEF, 0, 0);
    tbl[9]  = mk(0, NO, 32'h500, 32'hFFFFFFFF, 0, 32'h0, 0, 1, 32'h200, 32'h12345678, 32'hDEADBEEF, 0, 0);
    tbl[10] = mk(0, 2'b10, 32'h504, 32'h0, 1, 32'hBAD0BAD0, 0, 1, 32'h200, 32'h12345678, 32'hDEADBEEF, 0, 0);
    tbl[11] = mk(0, 2'b11, 32'h508, 32'h0, 1, 32'hBAD0BAD0, 0, 1, 32'h200, 32'h12345678, 32'hDEADBEEF, 0, 0);
    tbl[12] = mk(0, LD, 32'h300, 32'h0, 1, 32'hCAFEF00D, 0, 1, 32'h200, 32'h12345678, 32'hDEADBEEF, 1, 0);
    tbl[13] = mk(0, LD, 32'h300, 32'h0, 1, 32'hCAFEF00D, 1, 0, 32'h300, 32'h0, 32'hDEADBEEF, 1, 0);
    tbl[14] = mk(0, LD, 32'h300, 32'h0, 1, 32'hCAFEF00D, 0, 0, 32'h300, 32'h0, 32'hCAFEF00D, 0, 0);
    tbl[15] = mk(1, NO, 32'h304, 32'hA5A5A5A5, 1, 32'h0, 0, 0, 32'h300, 32'h0, 32'hCAFEF00D, 1, 0);
    tbl[16] = mk(1, NO, 32'h304, 32'hA5A5A5A5, 1, 32'h0, 1, 1, 32'h304, 32'hA5A5A5A5, 32'hCAFEF00D, 1, 0);
    tbl[17] = mk(1, NO, 32'h304, 32'hA5A5A5A5, 1, 32'h0, 0, 1, 32'h304, 32'hA5A5A5A5, 32'hCAFEF00D, 0, 0);
    tbl[18] = mk(0, NO, 32'h0, 32'h0, 1, 32'h0, 0, 1, 32'h304, 32'hA5A5A5A5, 32'hCAFEF00D, 0, 0);
    tbl[19] = mk(0, LD, 32'h400, 32'h0, 0, 32'h11111111, 0, 1, 32'h304, 32'hA5A5A5A5, 32'hCAFEF00D, 1, 0);
    tbl[20] = mk(0, LD, 32'h400, 32'h0, 0, 32'h22222222, 1, 0, 32'h400, 32'h0, 32'hCAFEF00D, 1, 0);
    tbl[21] = mk(0, LD, 32'h400, 32'h0, 1, 32'h33333333, 1, 0, 32'h400, 32'h0, 32'hCAFEF00D, 1, 0);
    tbl[22] = mk(0, LD, 32'h400, 32'h0, 1, 32'h44444444, 0, 0, 32'h400, 32'h0, 32'h33333333, 0, 0);
    tbl[23] = mk(0, NO, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'h400, 32'h0, 32'h33333333, 0, 0);

    // Reset with a load in M: every output must be low
    rst_n = 1'b0;
    drive(mk(0, LD, 32'h100, 32'h55, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #3;
    expect_out("reset", mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0));
    drive(mk(0, NO, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 24; i++) begin
      apply_vec($sformatf("row%0d", i), tbl[i]);
    end

    n_vec++;
    if (n_hs != 5) begin
      n_err++;
      $display("FAIL handshakes: got %0d, want 5", n_hs);
    end

    // Reset pulled mid-BUSY, between clock edges
    apply_vec("rst_idle", mk(0, LD, 32'h600, 32'h0, 0, 32'h0, 0, 0, 32'h400, 32'h0, 32'h33333333, 1, 0));
    v = mk(0, LD, 32'h600, 32'h0, 0, 32'h0, 1, 0, 32'h600, 32'h0, 32'h33333333, 1, 0);
    drive(v);
    #2;
    expect_out("rst_busy", v);
    #1;
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0));
    drive(mk(0, NO, 32'h0, 32'h0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply_vec("post_rst", mk(0, NO, 32'h0, 32'h0, 1, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0));
    apply_vec("pr_idle", mk(0, LD, 32'h800, 32'h0, 1, 32'h5A5A5A5A, 0, 0, 32'h0, 32'h0, 32'h0, 1, 0));
    apply_vec("pr_busy", mk(0, LD, 32'h800, 32'h0, 1, 32'h5A5A5A5A, 1, 0, 32'h800, 32'h0, 32'h0, 1, 0));
    apply_vec("pr_done", mk(0, LD, 32'h800, 32'h0, 1, 32'h5A5A5A5A, 0, 0, 32'h800, 32'h0, 32'h5A5A5A5A, 0, 0));

`ifdef MEM_TIMEOUT_EN
    // Ready on the last allowed BUSY cycle wins over the timeout
    apply_vec("pri_idle", mk(0, LD, 32'hA00, 32'h0, 0, 32'h0, 0, 0, 32'h800, 32'h0, 32'h5A5A5A5A, 1, 0));
    for (int i = 0; i < 3; i++) begin
      apply_vec($sformatf("pri_wait%0d", i),
                mk(0, LD, 32'hA00, 32'h0, 0, 32'h0, 1, 0, 32'hA00, 32'h0, 32'h5A5A5A5A, 1, 0));
    end
    apply_vec("pri_rdy", mk(0, LD, 32'hA00, 32'h0, 1, 32'h77777777, 1, 0, 32'hA00, 32'h0, 32'h5A5A5A5A, 1, 0));
    apply_vec("pri_done", mk(0, LD, 32'hA00, 32'h0, 0, 32'h0, 0, 0, 32'hA00, 32'h0, 32'h77777777, 0, 0));

    apply_vec("to_idle", mk(0, LD, 32'hB00, 32'h0, 0, 32'h99999999, 0, 0, 32'hA00, 32'h0, 32'h77777777, 1, 0));
    for (int i = 0; i < 4; i++) begin
      apply_vec($sformatf("to_wait%0d", i),
                mk(0, LD, 32'hB00, 32'h0, 0, 32'h99999999, 1, 0, 32'hB00, 32'h0, 32'h77777777, 1, 0));
    end
    apply_vec("to_done", mk(0, LD, 32'hB00, 32'h0, 0, 32'h99999999, 0, 0, 32'hB00, 32'h0, 32'h0, 0, 1));
    apply_vec("to_after", mk(0, NO, 32'h0, 32'h0, 0, 32'h0, 0, 0, 32'hB00, 32'h0, 32'h0, 0, 0));
`else
    // Without the timeout a stuck memory holds the request well past TIMEOUT_CYC
    apply_vec("long_idle", mk(0, LD, 32'hC00, 32'h0, 0, 32'h0, 0, 0, 32'h800, 32'h0, 32'h5A5A5A5A, 1, 0));
    for (int i = 0; i < 300; i++) begin
      apply_vec($sformatf("long_wait%0d", i),
                mk(0, LD, 32'hC00, 32'h0, 0, 32'h0, 1, 0, 32'hC00, 32'h0, 32'h5A5A5A5A, 1, 0));
    end
    apply_vec("long_rdy", mk(0, LD, 32'hC00, 32'h0, 1, 32'h13572468, 1, 0, 32'hC00, 32'h0, 32'h5A5A5A5A, 1, 0));
    apply_vec("long_done", mk(0, LD, 32'hC00, 32'h0, 0, 32'h0, 0, 0, 32'hC00, 32'h0, 32'h13572468, 0, 0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/c_mem_access_ctrl.md
Name: c_mem_access_ctrl

Overview:
- Sequences data-memory accesses for the instruction in the Memory stage of the 5-stage RV32 pipeline against a variable-latency memory with a req/ready handshake.
- Freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/M registers) while an access is outstanding.
- Injects a bubble into the M/W register while an access is outstanding.
- Returns load data aligned with the cycle the instruction leaves M.

Parameters:
- ADDR_W, 32, width of the memory address (taken from ALUResultM)
- DATA_W, 32, width of the data bus
- TIMEOUT_CYC, 255, maximum BUSY cycles before abort (used only with MEM_TIMEOUT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- MemWriteM  in  1  store in M stage
- ResultSrcM  in  2  result select in M stage; 2'b01 = load
- ALUResultM  in  ADDR_W  effective address
- WriteDataM  in  DATA_W  store data
- mem_req  out  1  request valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  request address
- mem_wdata  out  DATA_W  write data
- mem_ready  in  1  memory accepts/completes request this cycle
- mem_rdata  in  DATA_W  read data, valid when mem_req & mem_ready & !mem_we
- ReadDataM  out  DATA_W  registered load result
- StallMem  out  1  freeze PC, IF/ID, ID/EX, EX/M
- FlushW  out  1  load bubble into M/W register
- MemErr  out  1  one-cycle timeout pulse (tied 0 without MEM_TIMEOUT_EN)

Behaviour:
- access = MemWriteM | (ResultSrcM == 2'b01).
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- IDLE:
  - If access: latch mem_addr, mem_wdata and mem_we (mem_we = MemWriteM), then go to BUSY.
  - Otherwise stay in IDLE.
  - StallMem = access (combinational) in this state.
- BUSY:
  - mem_req = 1, and addr/we/wdata are held stable.
  - StallMem = 1.
  - On mem_req & mem_ready: for a read, capture mem_rdata into ReadDataM; go to DONE.
- DONE:
  - mem_req = 0, StallMem = 0; the pipeline advances the completed instruction to W.
  - Next state is IDLE unconditionally. The completed access is never re-issued.
- FlushW = StallMem in all states.
- mem_req is a registered output: it is 1 iff state == BUSY.
- Minimum latency with mem_ready already high: the access takes 3 cycles in M (IDLE-stall, BUSY, DONE).
- Each extra wait cycle of mem_ready adds one BUSY cycle.
- Back-to-back accesses:
  - After DONE the FSM is in IDLE with a new instruction in M.
  - A new access causes an immediate stall; there is no lost or duplicated request.
- Stores leave ReadDataM unchanged.
- Reset values: mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, ReadDataM 0, MemErr 0, state IDLE. StallMem and FlushW are 0 while reset is asserted.
- Reset asserted mid-BUSY: outputs clear asynchronously and mem_req drops immediately. The request is abandoned, and the memory must tolerate withdrawal.
- mem_ready is ignored outside BUSY.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - An 8+ bit counter clears on IDLE->BUSY and increments each BUSY cycle without mem_ready.
  - When the count reaches TIMEOUT_CYC, the FSM goes to DONE, drops mem_req, and loads ReadDataM = 0 for reads.
  - MemErr pulses 1 for exactly the DONE cycle.
  - mem_ready in the same cycle as the timeout takes priority (normal completion, no MemErr).
- Without the macro: BUSY waits indefinitely and MemErr is constant 0.

Decomposition:
- Package c_mem_pkg:
  - FSM state enum (IDLE/BUSY/DONE)
  - constant RESULT_SRC_MEM = 2'b01
  - default widths ADDR_W/DATA_W
- One natural sub-module: c_mem_timer, the timeout counter, instantiated only under MEM_TIMEOUT_EN. All else stays flat.

Test Plan:
- Load with zero wait: ResultSrcM=01, ALUResultM=0x100, mem_ready=1, mem_rdata=0xDEADBEEF -> StallMem high for 2 cycles; mem_req for 1 cycle, mem_we=0, mem_addr=0x100; ReadDataM=0xDEADBEEF in DONE; StallMem=0 in DONE.
- Store with 3 wait cycles: MemWriteM=1, addr 0x200, WriteDataM=0x12345678, mem_ready low 3 cycles -> mem_req held 4 cycles with stable addr/wdata, mem_we=1; ReadDataM unchanged; FlushW=StallMem throughout.
- Back-to-back load then store -> exactly two mem_req handshakes, one DONE cycle between them, no duplicate request.
- Reset asserted in BUSY -> mem_req, StallMem and ReadDataM all 0 without a clock edge; FSM in IDLE after release.
- Non-memory instruction (MemWriteM=0, ResultSrcM=00) -> StallMem=0, mem_req=0 for all cycles.
- MEM_TIMEOUT_EN, TIMEOUT_CYC=4, mem_ready stuck 0 -> mem_req for 4 cycles, then DONE with MemErr=1 for one cycle, ReadDataM=0, pipeline released.
